// File: rtl/serv_alu_seq.sv
// serv_alu_seq: per-instruction sequencer in front of the bit-serial ALU.
// It accepts one instruction on a valid/ready handshake and steps it through
// the serial phases IDLE -> [INIT] -> [RUN] -> DONE. From the registered state
// and bit counter it produces the ALU strobes (init, shift-amount capture,
// run enable, rd write-back) and the bit index. At the end of INIT it latches
// the serial compare result as the branch-taken flag.
// Optional build macro: SERV_ALU_SEQ_STALL_EN adds an i_stall input. While
// i_stall is high, INIT and RUN are frozen and their strobes are masked.
module serv_alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
`ifdef SERV_ALU_SEQ_STALL_EN
    input  logic                       i_stall,
`endif
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_need_init,
    input  logic                       i_is_branch,
    input  logic                       i_cmp,
    output logic                       o_init,
    output logic                       o_shamt_en,
    output logic                       o_en,
    output logic [$clog2(WIDTH)-1:0]   o_cnt,
    output logic                       o_rd_we,
    output logic                       o_take,
    output logic                       o_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW:0] SHAMT_LIM = (CW+1)'(SHAMT_W);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_branch_q;
    logic            take_q;
    logic            stall;
    logic            last;

`ifdef SERV_ALU_SEQ_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    // WIDTH is a power of two, so the last bit of a phase is all-ones.
    // Letting cnt wrap naturally returns it to 0 for the next phase.
    assign last = &cnt;

    // Phase sequencing. Each phase length counts only unstalled cycles.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            is_branch_q <= 1'b0;
            take_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        is_branch_q <= i_is_branch;
                        take_q      <= 1'b0;
                        cnt         <= '0;
                        state       <= i_need_init ? INIT : RUN;
                    end
                end
                INIT: begin
                    if (!stall) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            // Compare result is final after the whole word has shifted through.
                            take_q <= is_branch_q & i_cmp;
                            // Branches have no write-back, so they skip RUN.
                            state  <= is_branch_q ? DONE : RUN;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        cnt <= cnt + 1'b1;
                        if (last) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from registered state and cnt. A stall only masks them.
    assign o_ready    = (state == IDLE);
    assign o_init     = (state == INIT) && !stall;
    assign o_shamt_en = o_init && ({1'b0, cnt} < SHAMT_LIM);
    assign o_en       = (state == RUN) && !stall;
    assign o_rd_we    = o_en;
    assign o_done     = (state == DONE);
    assign o_cnt      = cnt;
    assign o_take     = take_q;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Self-checking bench for serv_alu_seq. Each issued instruction pushes its
// expected completion latency and take flag onto a scoreboard. The entry is
// popped and compared when o_done appears.
module tb_serv_alu_seq;
    localparam int W  = 32;
    localparam int SH = 5;

    logic         clk = 1'b0;
    logic         i_rst_n;
    logic         i_stall;
    logic         i_valid;
    logic         o_ready;
    logic         i_need_init;
    logic         i_is_branch;
    logic         i_cmp;
    logic         o_init;
    logic         o_shamt_en;
    logic         o_en;
    logic [4:0]   o_cnt;
    logic         o_rd_we;
    logic         o_take;
    logic         o_done;

    typedef struct {
        int lat;
        bit take;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    serv_alu_seq #(.WIDTH(W), .SHAMT_W(SH)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
`ifdef SERV_ALU_SEQ_STALL_EN
        .i_stall     (i_stall),
`endif
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_need_init (i_need_init),
        .i_is_branch (i_is_branch),
        .i_cmp       (i_cmp),
        .o_init      (o_init),
        .o_shamt_en  (o_shamt_en),
        .o_en        (o_en),
        .o_cnt       (o_cnt),
        .o_rd_we     (o_rd_we),
        .o_take      (o_take),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    // Entered right after an accept edge (posedge + #1). Drives i_cmp and
    // i_stall, checks every cycle, and returns at the negedge of the done cycle.
    task automatic monitor(input bit ni, input bit br, input bit cmp, input int stall_len);
        int  en_n = 0, init_n = 0, sh_n = 0, wr_n = 0;
        int  stall_left = stall_len;
        bit  stalling = 0;
        bit  cnt_bad = 0, excl_bad = 0, rdy_bad = 0, sh_bad = 0, stall_bad = 0;
        bit  done_seen = 0;
        exp_t e;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            // Stall decision at the start of the cycle. The stall begins once RUN reaches cnt=10.
            if (stall_left > 0 && (stalling || (o_en && o_cnt == 5'd10))) begin
                i_stall = 1'b1; stalling = 1; stall_left--;
            end else begin
                i_stall = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) begin
                checks++;
                if (o_take !== 1'b0) begin
                    errors++; $display("FAIL take_clear_on_accept: got %0b want 0", o_take);
                end
            end
            if (i_stall && (o_en !== 1'b0 || o_rd_we !== 1'b0 || o_cnt !== 5'd10)) stall_bad = 1;
            if (o_init && o_en) excl_bad = 1;
            if (o_en && o_cnt !== en_n[4:0]) cnt_bad = 1;
            if (o_init && o_cnt !== init_n[4:0]) cnt_bad = 1;
            if (o_shamt_en !== (o_init && o_cnt < SH)) sh_bad = 1;
            if (o_en) en_n++;
            if (o_init) init_n++;
            if (o_shamt_en) sh_n++;
            if (o_rd_we) wr_n++;
            if (o_done) begin
                done_seen = 1;
                if (o_ready !== 1'b0) rdy_bad = 1;
                e = sb.pop_front();
                checks++;
                if (cyc != e.lat) begin
                    errors++; $display("FAIL done_latency: got %0d want %0d", cyc, e.lat);
                end
                checks++;
                if (o_take !== e.take) begin
                    errors++; $display("FAIL take: got %0b want %0b", o_take, e.take);
                end
                break;
            end
            if (o_ready !== 1'b0) rdy_bad = 1;
            // The compare is only meaningful on the last INIT bit. Drive the opposite value elsewhere.
            i_cmp = (o_init && o_cnt == 5'(W-1)) ? cmp : ~cmp;
        end
        i_stall = 1'b0;
        checks++;
        if (!done_seen) begin
            errors++; $display("FAIL done_timeout: got none want o_done");
            if (sb.size() > 0) void'(sb.pop_front());
        end
        checks++;
        if (en_n != (br ? 0 : W)) begin
            errors++; $display("FAIL en_cycles: got %0d want %0d", en_n, br ? 0 : W);
        end
        checks++;
        if (wr_n != (br ? 0 : W)) begin
            errors++; $display("FAIL rd_we_cycles: got %0d want %0d", wr_n, br ? 0 : W);
        end
        checks++;
        if (init_n != (ni ? W : 0)) begin
            errors++; $display("FAIL init_cycles: got %0d want %0d", init_n, ni ? W : 0);
        end
        checks++;
        if (sh_n != (ni ? SH : 0) || sh_bad) begin
            errors++; $display("FAIL shamt_en: got %0d cycles (bad=%0b) want %0d", sh_n, sh_bad, ni ? SH : 0);
        end
        checks++;
        if (cnt_bad || excl_bad || rdy_bad) begin
            errors++; $display("FAIL seq_shape: got cnt_bad=%0b excl_bad=%0b rdy_bad=%0b want all 0", cnt_bad, excl_bad, rdy_bad);
        end
        if (stall_len > 0) begin
            checks++;
            if (stall_bad) begin
                errors++; $display("FAIL stall_freeze: got strobe/cnt moving during stall want frozen at 10");
            end
        end
    endtask

    // Expected latency from the accept edge to o_done.
    function automatic int exp_lat(input bit ni, input bit br, input int stall_len);
        if (br)      return W + 1 + stall_len;
        else if (ni) return 2 * W + 1 + stall_len;
        else         return W + 1 + stall_len;
    endfunction

    // Called at a negedge with the sequencer idle.
    task automatic issue(input bit ni, input bit br, input bit cmp, input int stall_len);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_issue: got %0b want 1", o_ready);
        end
        i_valid = 1'b1; i_need_init = ni; i_is_branch = br;
        sb.push_back('{lat: exp_lat(ni, br, stall_len), take: br & cmp});
        @(posedge clk); #1;
        i_valid = 1'b0; i_need_init = 1'b0; i_is_branch = 1'b0;
        monitor(ni, br, cmp, stall_len);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_valid = 1'b0; i_need_init = 1'b0; i_is_branch = 1'b0;
        i_cmp = 1'b0; i_stall = 1'b0;
        #12;
        checks++;
        if ({o_ready, o_init, o_shamt_en, o_en, o_rd_we, o_take, o_done} !== 7'b1000000 || o_cnt !== 5'd0) begin
            errors++; $display("FAIL reset_state: got outs=%b cnt=%0d want 1000000 cnt=0",
                {o_ready, o_init, o_shamt_en, o_en, o_rd_we, o_take, o_done}, o_cnt);
        end
        @(negedge clk); i_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;    issue(1'b0, 1'b0, 1'b0, 0); endtask
    task automatic test_shift;  issue(1'b1, 1'b0, 1'b1, 0); endtask
    task automatic test_branch;
        issue(1'b1, 1'b1, 1'b1, 0);
        @(negedge clk);
        issue(1'b1, 1'b1, 1'b0, 0);
    endtask

    // i_valid is held high across two instructions. The second accept must not occur before o_ready returns.
    task automatic test_back_to_back;
        i_valid = 1'b1; i_need_init = 1'b1; i_is_branch = 1'b1;
        sb.push_back('{lat: exp_lat(1'b1, 1'b1, 0), take: 1'b1});
        @(posedge clk); #1;
        i_need_init = 1'b0; i_is_branch = 1'b0;   // second instruction: ADD, valid held
        monitor(1'b1, 1'b1, 1'b1, 0);
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1 || o_take !== 1'b1 || o_en !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap: got ready=%0b take=%0b en=%0b want 1 1 0", o_ready, o_take, o_en);
        end
        sb.push_back('{lat: exp_lat(1'b0, 1'b0, 0), take: 1'b0});
        @(posedge clk); #1;
        i_valid = 1'b0;
        monitor(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        bit hit = 0;
        bit done_bad = 0, rdy_bad = 0;
        i_valid = 1'b1; i_need_init = 1'b0; i_is_branch = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (o_en && o_cnt == 5'd17) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL abort_reach_cnt17: got none want RUN cnt=17");
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_init, o_shamt_en, o_en, o_rd_we, o_take, o_done} !== 7'b1000000 || o_cnt !== 5'd0) begin
            errors++; $display("FAIL abort_async: got outs=%b cnt=%0d want 1000000 cnt=0",
                {o_ready, o_init, o_shamt_en, o_en, o_rd_we, o_take, o_done}, o_cnt);
        end
        @(negedge clk); @(negedge clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done) done_bad = 1;
            if (!o_ready) rdy_bad = 1;
        end
        checks++;
        if (done_bad || rdy_bad) begin
            errors++; $display("FAIL abort_no_done: got done=%0b notready=%0b want 0 0", done_bad, rdy_bad);
        end
        test_add();
        @(negedge clk);
    endtask

`ifdef SERV_ALU_SEQ_STALL_EN
    task automatic test_stall;  issue(1'b0, 1'b0, 1'b0, 3); @(negedge clk); endtask
`endif

    initial begin
        test_reset();
        test_add();
        @(negedge clk);
        test_shift();
        @(negedge clk);
        test_branch();
        @(negedge clk);
        test_back_to_back();
        test_reset_abort();
`ifdef SERV_ALU_SEQ_STALL_EN
        test_stall();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serv_alu_seq.md
Name: serv_alu_seq

Overview:
- Per-instruction sequencer sitting directly upstream of the serial ALU.
- Accepts one issued instruction via a valid/ready handshake and runs the bit-serial phases for it. It generates the ALU's enable, init and shift-amount-capture strobes, plus the bit counter.
- Latches the serial compare result at the end of the init phase for branch resolution.
- Signals completion to the decoder/PC logic.

Parameters:
- WIDTH, 32, data word width in bits = cycles per serial phase; power of two, ≥8.
- SHAMT_W, 5, shift-amount bits captured at start of init phase; must be ≤ WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  instruction issue request
- o_ready  out  1  sequencer idle, can accept issue
- i_need_init  in  1  instruction needs init phase (shift, branch); sampled on accept
- i_is_branch  in  1  instruction is a conditional branch; sampled on accept
- i_cmp  in  1  serial compare result from ALU
- o_init  out  1  ALU init strobe (init phase active)
- o_shamt_en  out  1  ALU shift-amount capture enable
- o_en  out  1  ALU run enable (execute phase active)
- o_cnt  out  log2(WIDTH)  current bit index within phase
- o_rd_we  out  1  serial write-back enable for rd
- o_take  out  1  branch-taken flag, valid while o_done=1
- o_done  out  1  single-cycle completion pulse

Behaviour:
- Reset, async on i_rst_n low: state IDLE, cnt=0, o_take=0, all strobes 0, o_ready=1. Deassertion is clean; first active edge afterwards evaluates IDLE.
- States: IDLE, INIT, RUN, DONE. Encoding is free; outputs are decoded from registered state and cnt only (no combinational input→output path except o_ready=(state==IDLE)).
- Accept: i_valid && o_ready at a rising edge. Latch need_init and is_branch. cnt←0. Next state is INIT if i_need_init, else RUN.
- INIT: o_init=1 for exactly WIDTH cycles.
  - o_shamt_en=1 while cnt<SHAMT_W, i.e. the first SHAMT_W cycles of INIT.
  - On the last INIT cycle (cnt=WIDTH-1): if is_branch, o_take←i_cmp; else o_take←0. Then cnt←0 and go to RUN, or to DONE if is_branch (branches skip RUN and do no write-back).
- RUN: o_en=1 and o_rd_we=1 for exactly WIDTH cycles. cnt increments every cycle. At cnt=WIDTH-1, go to DONE.
- DONE: o_done=1 for one cycle; o_take holds its value. Then go to IDLE. o_ready=0 in DONE, so no back-to-back accept in the same cycle.
- Latency, accept edge to o_done high:
  - WIDTH+1 cycles without init.
  - 2·WIDTH+1 cycles with init, non-branch.
  - WIDTH+1 cycles for a branch.
- cnt wraps WIDTH-1→0 at every phase boundary. cnt is held at 0 in IDLE and DONE.
- o_take cleared on accept of a new instruction.
- i_valid while busy is ignored; it is not queued. The issuer must hold i_valid until o_ready.
- Reset asserted mid-phase aborts immediately to IDLE. No o_done is emitted for the aborted instruction.
- Strobes are mutually exclusive: o_init and o_en are never both 1.

Optional Feature:
- Macro SERV_ALU_SEQ_STALL_EN.
- Defined: adds port i_stall (in, 1), e.g. for a multi-cycle regfile read.
  - While i_stall=1 in INIT or RUN: cnt and state freeze, and o_init/o_en/o_shamt_en/o_rd_we are forced to 0.
  - i_stall has no effect in IDLE or DONE.
  - Phase length counts unstalled cycles only.
- Undefined: no i_stall port; phases always advance every cycle.

Test Plan:
- Reset then ADD-type issue (need_init=0) → o_en=1 for exactly 32 cycles with cnt 0..31; o_done at cycle 33 after accept; o_init never asserts.
- Shift issue (need_init=1, branch=0) → o_init for 32 cycles; o_shamt_en exactly on INIT cycles 0..4; then 32 cycles of o_en/o_rd_we; o_done at cycle 65.
- Branch issue, i_cmp=1 on INIT cycle 31 → o_done at cycle 33 with o_take=1, o_en/o_rd_we never asserted. Repeat with i_cmp=0 → o_take=0.
- i_valid held continuously across two instructions → second accept only on the cycle after o_done (o_ready=1), never earlier; second instruction's o_take starts at 0.
- Assert i_rst_n low at RUN cnt=17 → all outputs 0 and o_ready=1 immediately (asynchronously); no o_done; next issue runs the full 32 cycles.
- With SERV_ALU_SEQ_STALL_EN: ADD issue, i_stall=1 for 3 cycles at cnt=10 → cnt holds 10, o_en=0 during the stall; o_done arrives 3 cycles later than the unstalled case (cycle 36).
